// File: rtl/bptt_acc_ctrl_if.sv
// bptt_acc_ctrl_if: handshake bundle between the BPTT sequencer and its
// neighbours (training FSM, timestep store, delta unit, accumulators,
// weight-update stage). Optional abort input: BPTT_CTRL_ABORT_EN.
interface bptt_acc_ctrl_if #(
  parameter int ADDR_W = 2
);
  logic              i_start;
  logic              o_busy;
  logic              o_rd_en;
  logic [ADDR_W-1:0] o_addr;
  logic              i_d_valid;
  logic              o_d_ready;
  logic              o_acc_en;
  logic              o_acc_clr;
  logic              o_upd_en;
  logic              i_upd_done;
  logic              o_done;
`ifdef BPTT_CTRL_ABORT_EN
  logic              i_abort;

  // Controller side
  modport master (
    input  i_start, i_d_valid, i_upd_done, i_abort,
    output o_busy, o_rd_en, o_addr, o_d_ready, o_acc_en, o_acc_clr,
           o_upd_en, o_done
  );

  // Environment side
  modport slave (
    output i_start, i_d_valid, i_upd_done, i_abort,
    input  o_busy, o_rd_en, o_addr, o_d_ready, o_acc_en, o_acc_clr,
           o_upd_en, o_done
  );
`else
  // Controller side
  modport master (
    input  i_start, i_d_valid, i_upd_done,
    output o_busy, o_rd_en, o_addr, o_d_ready, o_acc_en, o_acc_clr,
           o_upd_en, o_done
  );

  // Environment side
  modport slave (
    output i_start, i_d_valid, i_upd_done,
    input  o_busy, o_rd_en, o_addr, o_d_ready, o_acc_en, o_acc_clr,
           o_upd_en, o_done
  );
`endif
endinterface

// File: rtl/bptt_acc_ctrl.sv
// bptt_acc_ctrl: LSTM backward-pass sequencer. Clears the gradient
// accumulators, walks the stored timesteps from N_STEP-1 down to 0
// (read, wait for deltas, accumulate), then requests the weight update.
// All outputs are registered and derived from the next state.
// Optional feature macro: BPTT_CTRL_ABORT_EN (adds bus.i_abort).
module bptt_acc_ctrl #(
  parameter int N_STEP = 4,
  parameter int ADDR_W = 2,
  parameter int LAT    = 2
) (
  input  logic                clk,
  input  logic                rst,
  bptt_acc_ctrl_if.master     bus
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CLEAR  = 3'd1;
  localparam logic [2:0] S_FETCH  = 3'd2;
  localparam logic [2:0] S_WAIT   = 3'd3;
  localparam logic [2:0] S_ACC    = 3'd4;
  localparam logic [2:0] S_UPDATE = 3'd5;
  localparam logic [2:0] S_DONE   = 3'd6;

  // Counts WAIT cycles (1 = first WAIT cycle); saturates at LAT.
  localparam int CNT_W = (LAT < 1) ? 1 : $clog2(LAT + 1);
  localparam logic [CNT_W-1:0]  LAT_C  = CNT_W'(LAT);
  localparam logic [ADDR_W-1:0] LAST_T = ADDR_W'(N_STEP - 1);

  logic [2:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              abort_clr;

  logic busy_q, busy_d;
  logic rd_en_q, rd_en_d;
  logic d_ready_q, d_ready_d;
  logic acc_en_q, acc_en_d;
  logic acc_clr_q, acc_clr_d;
  logic upd_en_q, upd_en_d;
  logic done_q, done_d;

  // Next-state, timestep index and latency counter.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    abort_clr = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.i_start) begin
          state_d = S_CLEAR;
          addr_d  = LAST_T;          // visible together with the clear pulse
        end
      end
      S_CLEAR:  state_d = S_FETCH;
      S_FETCH: begin
        cnt_d   = CNT_W'(1);
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // Ready is the registered flag, so acceptance uses what the
        // producer saw this cycle.
        if (bus.i_d_valid && d_ready_q) begin
          state_d = S_ACC;
        end else if (cnt_q < LAT_C) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_ACC: begin
        if (addr_q == '0) begin
          state_d = S_UPDATE;        // index stays at 0, never wraps
        end else begin
          addr_d  = addr_q - ADDR_W'(1);
          state_d = S_FETCH;
        end
      end
      S_UPDATE: begin
        if (bus.i_upd_done) state_d = S_DONE;
      end
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
`ifdef BPTT_CTRL_ABORT_EN
    // Abort overrides every transition; the clear pulse discards partial sums.
    if (state_q != S_IDLE && bus.i_abort) begin
      state_d   = S_IDLE;
      addr_d    = '0;
      abort_clr = 1'b1;
    end
`endif
  end

  // Moore outputs decoded from the next state so they register in step with it.
  always_comb begin
    busy_d    = (state_d != S_IDLE);
    rd_en_d   = (state_d == S_FETCH);
    d_ready_d = (state_d == S_WAIT) && (cnt_d >= LAT_C);
    acc_en_d  = (state_d == S_ACC);
    acc_clr_d = (state_d == S_CLEAR) || abort_clr;
    upd_en_d  = (state_d == S_UPDATE);
    done_d    = (state_d == S_DONE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      busy_q    <= 1'b0;
      rd_en_q   <= 1'b0;
      d_ready_q <= 1'b0;
      acc_en_q  <= 1'b0;
      acc_clr_q <= 1'b0;
      upd_en_q  <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      busy_q    <= busy_d;
      rd_en_q   <= rd_en_d;
      d_ready_q <= d_ready_d;
      acc_en_q  <= acc_en_d;
      acc_clr_q <= acc_clr_d;
      upd_en_q  <= upd_en_d;
      done_q    <= done_d;
    end
  end

  assign bus.o_busy    = busy_q;
  assign bus.o_rd_en   = rd_en_q;
  assign bus.o_addr    = addr_q;
  assign bus.o_d_ready = d_ready_q;
  assign bus.o_acc_en  = acc_en_q;
  assign bus.o_acc_clr = acc_clr_q;
  assign bus.o_upd_en  = upd_en_q;
  assign bus.o_done    = done_q;

endmodule

// File: tb/tb_bptt_acc_ctrl.sv
// tb_bptt_acc_ctrl: randomized + directed bench for bptt_acc_ctrl.
// A procedural pass model predicts every output each cycle; directed
// passes pin the model with hand-computed cycle counts.
// Optional feature macro exercised when defined: BPTT_CTRL_ABORT_EN.
module tb_bptt_acc_ctrl;
  localparam int N_STEP = 4;
  localparam int ADDR_W = 2;
  localparam int LAT    = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic d_valid = 1'b0;
  logic upd_done = 1'b0;
`ifdef BPTT_CTRL_ABORT_EN
  logic abort = 1'b0;
`endif

  always #5 clk = ~clk;

  bptt_acc_ctrl_if #(.ADDR_W(ADDR_W)) bus ();
  assign bus.i_start    = start;
  assign bus.i_d_valid  = d_valid;
  assign bus.i_upd_done = upd_done;
`ifdef BPTT_CTRL_ABORT_EN
  assign bus.i_abort    = abort;
`endif

  bptt_acc_ctrl #(.N_STEP(N_STEP), .ADDR_W(ADDR_W), .LAT(LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0d want %0d", name, cyc, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic e_busy = 0, e_rd = 0, e_rdy = 0, e_acc = 0, e_clr = 0, e_upd = 0, e_done = 0;
  int   e_addr = 0;
  bit   killed;

  task automatic put(input bit b, rd, rdy, acc, clr, upd, dn, input int a);
    e_busy = b; e_rd = rd; e_rdy = rdy; e_acc = acc;
    e_clr = clr; e_upd = upd; e_done = dn; e_addr = a;
  endtask

  // One clock edge inside a pass; reset (or abort) ends the pass.
  task automatic step();
    @(posedge clk);
    if (rst) begin
      put(0, 0, 0, 0, 0, 0, 0, 0);
      killed = 1;
    end
`ifdef BPTT_CTRL_ABORT_EN
    else if (abort) begin
      put(0, 0, 0, 0, 1, 0, 0, 0);
      killed = 1;
    end
`endif
  endtask

  // A whole backward pass as a script: clear, then per timestep
  // read / wait-for-deltas / accumulate, then update and done.
  task automatic run_pass();
    int k;
    killed = 0;
    put(1, 0, 0, 0, 1, 0, 0, N_STEP - 1);
    for (int t = N_STEP - 1; t >= 0; t--) begin
      step(); if (killed) return;
      put(1, 1, 0, 0, 0, 0, 0, t);
      step(); if (killed) return;
      k = 1;
      put(1, 0, (k >= LAT), 0, 0, 0, 0, t);
      forever begin
        step(); if (killed) return;
        if (k >= LAT && d_valid) break;
        k++;
        put(1, 0, (k >= LAT), 0, 0, 0, 0, t);
      end
      put(1, 0, 0, 1, 0, 0, 0, t);
    end
    step(); if (killed) return;
    put(1, 0, 0, 0, 0, 1, 0, 0);
    forever begin
      step(); if (killed) return;
      if (upd_done) break;
    end
    put(1, 0, 0, 0, 0, 0, 1, 0);
    step(); if (killed) return;
    put(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin : model
    forever begin
      @(posedge clk);
      if (!rst && start) run_pass();
      else put(0, 0, 0, 0, 0, 0, 0, 0);
    end
  end

  // Compare every output against the model in every cycle after the first edge.
  initial begin : compare
    forever begin
      @(negedge clk);
      if (cyc > 0) begin
        chk("busy",    bus.o_busy,    e_busy);
        chk("rd_en",   bus.o_rd_en,   e_rd);
        chk("addr",    bus.o_addr,    e_addr);
        chk("d_ready", bus.o_d_ready, e_rdy);
        chk("acc_en",  bus.o_acc_en,  e_acc);
        chk("acc_clr", bus.o_acc_clr, e_clr);
        chk("upd_en",  bus.o_upd_en,  e_upd);
        chk("done",    bus.o_done,    e_done);
      end
    end
  end

  // ---------------- input responders ----------------
  bit v_tied = 1, v_rand = 0, v_armed = 0;
  int v_delay = 0, v_cnt = 0;
  bit u_tied = 1;
  int u_delay = 0, u_cnt = 0;

  // Delta producer: raises valid v_delay cycles after a read, holds until accumulated.
  initial begin : valid_drv
    forever begin
      @(negedge clk);
      if (bus.o_rd_en) begin
        v_armed = 1;
        v_cnt = v_rand ? int'($urandom_range(0, 6)) : v_delay;
      end else if (bus.o_acc_en) begin
        v_armed = 0;
      end else if (v_cnt > 0) begin
        v_cnt--;
      end
      d_valid = v_tied ? 1'b1 : (v_armed && v_cnt == 0);
    end
  end

  // Weight-update stage: answers done after u_delay cycles of request.
  initial begin : upd_drv
    forever begin
      @(negedge clk);
      if (u_tied) begin
        upd_done = 1'b1;
      end else if (bus.o_upd_en) begin
        upd_done = (u_cnt >= u_delay);
        u_cnt++;
      end else begin
        upd_done = 1'b0;
        u_cnt = 0;
      end
    end
  end

  // ---------------- event monitor for literal pins ----------------
  int clr_cnt, acc_cnt, upd_cnt, done_cnt;
  int clr_cyc, rd_cyc, rdy_cyc, acc_cyc;
  logic [ADDR_W-1:0] rd_q[$];

  task automatic clear_mon();
    clr_cnt = 0; acc_cnt = 0; upd_cnt = 0; done_cnt = 0;
    clr_cyc = -1; rd_cyc = -1; rdy_cyc = -1; acc_cyc = -1;
    rd_q.delete();
  endtask

  initial begin : monitor
    clear_mon();
    forever begin
      @(negedge clk);
      if (bus.o_acc_clr) begin clr_cnt++; if (clr_cyc < 0) clr_cyc = cyc; end
      if (bus.o_rd_en) begin rd_q.push_back(bus.o_addr); if (rd_cyc < 0) rd_cyc = cyc; end
      if (bus.o_d_ready && rdy_cyc < 0) rdy_cyc = cyc;
      if (bus.o_acc_en) begin acc_cnt++; if (acc_cyc < 0) acc_cyc = cyc; end
      if (bus.o_upd_en) upd_cnt++;
      if (bus.o_done) done_cnt++;
    end
  end

  // ---------------- directed helpers ----------------
  int start_cyc;

  task automatic pulse_start();
    start = 1'b1;
    start_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  // kind 0: read of index a; 1: accumulate of index a; 2: done pulse.
  task automatic wait_ev(input int kind, input int a, input string name);
    bit hit = 0;
    for (int n = 0; n < 400 && !hit; n++) begin
      @(negedge clk);
      case (kind)
        0:       hit = bus.o_rd_en  && (int'(bus.o_addr) == a);
        1:       hit = bus.o_acc_en && (int'(bus.o_addr) == a);
        default: hit = bus.o_done;
      endcase
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL timeout_%s cycle %0d: event not seen, required within 400 cycles", name, cyc);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin : main
    logic [31:0] seq;
    repeat (3) @(negedge clk);
    chk("rst_busy", bus.o_busy, 0);
    chk("rst_addr", bus.o_addr, 0);
    chk("rst_done", bus.o_done, 0);
    rst = 1'b0;
    @(negedge clk);

    // T1: valid and update done tied high.
    clear_mon();
    pulse_start();
    wait_ev(2, 0, "t1_done");
    chk("t1_done_cyc", cyc - start_cyc, 19);
    chk("t1_clr_cyc", clr_cyc - start_cyc, 1);
    chk("t1_rd_cyc", rd_cyc - start_cyc, 2);
    chk("t1_acc_cnt", acc_cnt, 4);
    seq = 0;
    foreach (rd_q[i]) seq = (seq << 4) | 32'(rd_q[i]);
    chk("t1_addr_seq", seq, 32'h3210);
    repeat (2) @(negedge clk);

    // T2: valid arrives 5 cycles after each read.
    v_tied = 0; v_delay = 5;
    clear_mon();
    pulse_start();
    wait_ev(2, 0, "t2_done");
    chk("t2_done_cyc", cyc - start_cyc, 31);
    chk("t2_ready_lag", rdy_cyc - rd_cyc, 2);
    chk("t2_acc_lag", acc_cyc - rd_cyc, 6);
    chk("t2_acc_cnt", acc_cnt, 4);
    repeat (2) @(negedge clk);

    // T3: update stage answers after 10 cycles.
    v_tied = 1; u_tied = 0; u_delay = 10;
    clear_mon();
    pulse_start();
    wait_ev(2, 0, "t3_done");
    chk("t3_done_cyc", cyc - start_cyc, 29);
    chk("t3_upd_cnt", upd_cnt, 11);
    @(negedge clk);
    chk("t3_idle_busy", bus.o_busy, 0);
    u_tied = 1;
    repeat (2) @(negedge clk);

    // T4: start pulses mid-pass and alongside done are ignored.
    clear_mon();
    pulse_start();
    wait_ev(0, 2, "t4_rd2");
    start = 1'b1; @(negedge clk); start = 1'b0;
    wait_ev(2, 0, "t4_done");
    start = 1'b1; @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    chk("t4_clr_cnt", clr_cnt, 1);
    chk("t4_done_cnt", done_cnt, 1);
    chk("t4_busy", bus.o_busy, 0);
    clear_mon();
    pulse_start();
    wait_ev(2, 0, "t4b_done");
    chk("t4b_done_cyc", cyc - start_cyc, 19);
    repeat (2) @(negedge clk);

    // T5: reset while waiting on index 2, then restart.
    v_tied = 0; v_delay = 5;
    clear_mon();
    pulse_start();
    wait_ev(0, 2, "t5_rd2");
    @(negedge clk);
    chk("t5_wait_addr", bus.o_addr, 2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t5_rst_busy", bus.o_busy, 0);
    chk("t5_rst_addr", bus.o_addr, 0);
    chk("t5_rst_rd", bus.o_rd_en, 0);
    clear_mon();
    pulse_start();
    chk("t5_clr", bus.o_acc_clr, 1);
    chk("t5_addr3", bus.o_addr, 3);
    wait_ev(2, 0, "t5_done");
    chk("t5_done_cyc", cyc - start_cyc, 31);
    repeat (2) @(negedge clk);

`ifdef BPTT_CTRL_ABORT_EN
    // T6: abort while accumulating index 1.
    v_tied = 1; u_tied = 1;
    clear_mon();
    pulse_start();
    wait_ev(1, 1, "t6_acc1");
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("t6_clr", bus.o_acc_clr, 1);
    chk("t6_busy", bus.o_busy, 0);
    repeat (5) @(negedge clk);
    chk("t6_upd_cnt", upd_cnt, 0);
    chk("t6_done_cnt", done_cnt, 0);
`endif

    // T7: random traffic, checked cycle by cycle against the model.
    v_rand = 1; u_tied = 0;
    for (int i = 0; i < 800; i++) begin
      if (i % 50 == 0) begin
        v_tied  = bit'($urandom_range(0, 1));
        u_delay = int'($urandom_range(0, 4));
      end
      start = ($urandom_range(0, 7) == 0);
      rst   = ($urandom_range(0, 149) == 0);
`ifdef BPTT_CTRL_ABORT_EN
      abort = ($urandom_range(0, 99) == 0);
`endif
      @(negedge clk);
    end
    start = 1'b0; rst = 1'b0;
`ifdef BPTT_CTRL_ABORT_EN
    abort = 1'b0;
`endif
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
